// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, pipeline-register triple and bubble constant for the
// integer pipeline back end (wb_regfile and its read ports).
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DW     = 32;

  localparam logic [DW-1:0] ZERO_WORD = '0;

  // One result in flight: destination, write enable, data.
  typedef struct packed {
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [DW-1:0]     wdata;
  } wb_triple_t;

  // Empty pipeline slot: never commits and never matches a bypass.
  localparam wb_triple_t WB_BUBBLE = '{wd: '0, wreg: 1'b0, wdata: ZERO_WORD};

endpackage

// File: rtl/wb_regfile_read_port.sv
// rf_read_port: combinational priority mux for one register-file read port.
// Returns the youngest in-flight result for the requested address, falling
// back to the register array.
//
// Ports:
//   re, raddr          read enable and address
//   ex_*  / mem_*      EX-stage and EX/MEM bypass sources (WB_REGFILE_FORWARD_EN only)
//   wb_*               MEM/WB bypass source (always present)
//   rf_data            register array contents at raddr
//   rdata              selected read data
//
// Build option: WB_REGFILE_FORWARD_EN compiles in the EX and MEM bypass legs.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DW     = 32
) (
  input  logic              re,
  input  logic [REG_AW-1:0] raddr,
`ifdef WB_REGFILE_FORWARD_EN
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DW-1:0]     ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DW-1:0]     mem_wdata,
`endif
  input  logic              wb_wreg,
  input  logic [REG_AW-1:0] wb_wd,
  input  logic [DW-1:0]     wb_wdata,
  input  logic [DW-1:0]     rf_data,
  output logic [DW-1:0]     rdata
);

  // Priority order: disabled, r0, EX, MEM, WB, array. Youngest stage wins.
  always_comb begin
    rdata = '0;
    if (!re) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
`ifdef WB_REGFILE_FORWARD_EN
    end else if (ex_wreg && (ex_wd == raddr)) begin
      rdata = ex_wdata;
    end else if (mem_wreg && (mem_wd == raddr)) begin
      rdata = mem_wdata;
`endif
    end else if (wb_wreg && (wb_wd == raddr)) begin
      rdata = wb_wdata;
    end else begin
      rdata = rf_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: EX/MEM and MEM/WB pipeline registers, 32x32 general register
// file with writeback commit, and two bypassed decode-stage read ports.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   stall_i, flush_i               hold / bubble both pipeline registers (flush wins)
//   ex_wd_i, ex_wreg_i, ex_wdata_i EX-stage result triple
//   re1_i, raddr1_i, rdata1_o      read port 1
//   re2_i, raddr2_i, rdata2_o      read port 2
//   mem_wd_o, mem_wreg_o, mem_wdata_o  EX/MEM register contents
//   wb_wd_o,  wb_wreg_o,  wb_wdata_o   MEM/WB register contents
//
// Build option: WB_REGFILE_FORWARD_EN enables EX and MEM bypass on reads.
module wb_regfile #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned REG_AW  = cpu_pkg::REG_AW,
  parameter int unsigned DW      = cpu_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DW-1:0]     ex_wdata_i,
  input  logic              re1_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DW-1:0]     rdata1_o,
  input  logic              re2_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DW-1:0]     rdata2_o,
  output logic [REG_AW-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [REG_AW-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DW-1:0]     wb_wdata_o
);

  import cpu_pkg::*;

  wb_triple_t    mem_q;
  wb_triple_t    wb_q;
  wb_triple_t    ex_in;
  logic [DW-1:0] regs [REG_NUM];

  assign ex_in = '{wd: ex_wd_i, wreg: ex_wreg_i, wdata: ex_wdata_i};

  // Pipeline registers: flush has priority over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= WB_BUBBLE;
      wb_q  <= WB_BUBBLE;
    end else if (flush_i) begin
      mem_q <= WB_BUBBLE;
      wb_q  <= WB_BUBBLE;
    end else if (!stall_i) begin
      mem_q <= ex_in;
      wb_q  <= mem_q;
    end
  end

  // Commit ignores stall and flush: re-writing a held WB entry is harmless,
  // and the entry leaving WB on a flush edge is architecturally retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_q.wreg && (wb_q.wd != '0)) begin
      regs[wb_q.wd] <= wb_q.wdata;
    end
  end

  assign mem_wd_o    = mem_q.wd;
  assign mem_wreg_o  = mem_q.wreg;
  assign mem_wdata_o = mem_q.wdata;
  assign wb_wd_o     = wb_q.wd;
  assign wb_wreg_o   = wb_q.wreg;
  assign wb_wdata_o  = wb_q.wdata;

  rf_read_port #(
    .REG_AW (REG_AW),
    .DW     (DW)
  ) u_port1 (
    .re        (re1_i),
    .raddr     (raddr1_i),
`ifdef WB_REGFILE_FORWARD_EN
    .ex_wreg   (ex_wreg_i),
    .ex_wd     (ex_wd_i),
    .ex_wdata  (ex_wdata_i),
    .mem_wreg  (mem_q.wreg),
    .mem_wd    (mem_q.wd),
    .mem_wdata (mem_q.wdata),
`endif
    .wb_wreg   (wb_q.wreg),
    .wb_wd     (wb_q.wd),
    .wb_wdata  (wb_q.wdata),
    .rf_data   (regs[raddr1_i]),
    .rdata     (rdata1_o)
  );

  rf_read_port #(
    .REG_AW (REG_AW),
    .DW     (DW)
  ) u_port2 (
    .re        (re2_i),
    .raddr     (raddr2_i),
`ifdef WB_REGFILE_FORWARD_EN
    .ex_wreg   (ex_wreg_i),
    .ex_wd     (ex_wd_i),
    .ex_wdata  (ex_wdata_i),
    .mem_wreg  (mem_q.wreg),
    .mem_wd    (mem_q.wd),
    .mem_wdata (mem_q.wdata),
`endif
    .wb_wreg   (wb_q.wreg),
    .wb_wd     (wb_q.wd),
    .wb_wdata  (wb_q.wdata),
    .rf_data   (regs[raddr2_i]),
    .rdata     (rdata2_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile. Expectations for the
// forwarding window depend on WB_REGFILE_FORWARD_EN, matching the build.
`timescale 1ns/1ps
module tb_wb_regfile;

`ifdef WB_REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [4:0]  mem_wd, wb_wd;
  logic        mem_wreg, wb_wreg;
  logic [31:0] mem_wdata, wb_wdata;

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .ex_wd_i     (ex_wd),
    .ex_wreg_i   (ex_wreg),
    .ex_wdata_i  (ex_wdata),
    .re1_i       (re1),
    .raddr1_i    (raddr1),
    .rdata1_o    (rdata1),
    .re2_i       (re2),
    .raddr2_i    (raddr2),
    .rdata2_o    (rdata2),
    .mem_wd_o    (mem_wd),
    .mem_wreg_o  (mem_wreg),
    .mem_wdata_o (mem_wdata),
    .wb_wd_o     (wb_wd),
    .wb_wreg_o   (wb_wreg),
    .wb_wdata_o  (wb_wdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Pop the next scoreboard entry and compare it against a DUT value.
  task automatic chk_sb(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_ex(input logic [4:0] wd, input logic w, input logic [31:0] d);
    ex_wd    = wd;
    ex_wreg  = w;
    ex_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;

    vecs[0] = '{wd: 5'd1,  wreg: 1'b1, wdata: 32'h1111_1111, exp: 32'h1111_1111};
    vecs[1] = '{wd: 5'd31, wreg: 1'b1, wdata: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
    vecs[2] = '{wd: 5'd0,  wreg: 1'b1, wdata: 32'hCAFE_F00D, exp: 32'h0000_0000};
    vecs[3] = '{wd: 5'd12, wreg: 1'b0, wdata: 32'h0000_ABCD, exp: 32'h0000_0000};
    vecs[4] = '{wd: 5'd20, wreg: 1'b1, wdata: 32'h8000_0001, exp: 32'h8000_0001};
    vecs[5] = '{wd: 5'd2,  wreg: 1'b1, wdata: 32'h0F0F_0F0F, exp: 32'h0F0F_0F0F};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_ex(5'd0, 1'b0, 32'h0);
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;

    // Reset state
    #2;
    chk("rst_mem_wreg", {31'b0, mem_wreg}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_wb_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      #1;
      chk("rst_rd1", rdata1, 32'h0);
      chk("rst_rd2", rdata2, 32'h0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Forwarding window: r5 <= 0x12345678 presented in cycle N
    tick();
    drive_ex(5'd5, 1'b1, 32'h1234_5678);
    raddr1 = 5'd5;
    exp_q.push_back(FWD ? 32'h1234_5678 : 32'h0);
    exp_q.push_back(FWD ? 32'h1234_5678 : 32'h0);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    settle();
    chk_sb("fwd_n0", rdata1);
    tick();
    drive_ex(5'd0, 1'b0, 32'h0);
    settle();
    chk_sb("fwd_n1", rdata1);
    chk("fwd_mem_wd", {27'b0, mem_wd}, 32'd5);
    chk("fwd_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    settle();
    chk_sb("fwd_n2", rdata1);
    chk("fwd_wb_wdata", wb_wdata, 32'h1234_5678);
    tick();
    settle();
    chk_sb("fwd_n3", rdata1);
    chk("fwd_wb_bubble", {31'b0, wb_wreg}, 32'h0);

    // Back-to-back writes to r7
    tick();
    drive_ex(5'd7, 1'b1, 32'hA);
    raddr1 = 5'd7;
    tick();
    drive_ex(5'd7, 1'b1, 32'hB);
    settle();
    chk("b2b_n1", rdata1, FWD ? 32'hB : 32'h0);
    tick();
    drive_ex(5'd0, 1'b0, 32'h0);
    settle();
    chk("b2b_n2", rdata1, FWD ? 32'hB : 32'hA);
    tick();
    settle();
    chk("b2b_n3", rdata1, 32'hB);
    tick();
    settle();
    chk("b2b_drained", rdata1, 32'hB);
    re1 = 1'b0;
    #1;
    chk("re1_off", rdata1, 32'h0);
    re1 = 1'b1;

    // Write to r0 is discarded
    tick();
    drive_ex(5'd0, 1'b1, 32'hFFFF_FFFF);
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("r0_p1", rdata1, 32'h0);
      chk("r0_p2", rdata2, 32'h0);
      tick();
      drive_ex(5'd0, 1'b0, 32'h0);
    end

    // Stall with r9 <= 0x55 in MEM
    drive_ex(5'd9, 1'b1, 32'h55);
    tick();
    stall = 1'b1;
    drive_ex(5'd10, 1'b1, 32'h66);
    raddr1 = 5'd10;
    raddr2 = 5'd9;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("stall_mem_wd", {27'b0, mem_wd}, 32'd9);
      chk("stall_mem_wdata", mem_wdata, 32'h55);
      chk("stall_wb_wreg", {31'b0, wb_wreg}, 32'h0);
      chk("stall_rd2", rdata2, FWD ? 32'h55 : 32'h0);
      tick();
    end
    stall = 1'b0;
    drive_ex(5'd0, 1'b0, 32'h0);
    settle();
    chk("stall_held_mem", mem_wdata, 32'h55);
    tick();
    settle();
    chk("unstall_wb_wd", {27'b0, wb_wd}, 32'd9);
    chk("unstall_wb_wdata", wb_wdata, 32'h55);
    tick();
    settle();
    chk("unstall_r9", rdata2, 32'h55);
    chk("unstall_wb_bubble", {31'b0, wb_wreg}, 32'h0);
    chk("stall_r10_unwritten", rdata1, 32'h0);

    // Flush + stall: r3 in MEM dropped, r4 in WB still commits
    tick();
    drive_ex(5'd4, 1'b1, 32'h44);
    tick();
    drive_ex(5'd3, 1'b1, 32'h77);
    tick();
    drive_ex(5'd0, 1'b0, 32'h0);
    flush = 1'b1;
    stall = 1'b1;
    settle();
    chk("preflush_mem_wd", {27'b0, mem_wd}, 32'd3);
    chk("preflush_wb_wd", {27'b0, wb_wd}, 32'd4);
    tick();
    flush = 1'b0;
    stall = 1'b0;
    raddr1 = 5'd4;
    raddr2 = 5'd3;
    settle();
    chk("flush_mem_wreg", {31'b0, mem_wreg}, 32'h0);
    chk("flush_mem_wdata", mem_wdata, 32'h0);
    chk("flush_mem_wd", {27'b0, mem_wd}, 32'h0);
    chk("flush_wb_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("flush_wb_wdata", wb_wdata, 32'h0);
    chk("flush_r4", rdata1, 32'h44);
    chk("flush_r3", rdata2, 32'h0);
    tick();
    tick();
    settle();
    chk("flush_r3_later", rdata2, 32'h0);
    chk("flush_r4_later", rdata1, 32'h44);

    // Table of writes, drained and read back on both ports
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_ex(vecs[i].wd, vecs[i].wreg, vecs[i].wdata);
      exp_q.push_back(vecs[i].exp);
      tick();
    end
    drive_ex(5'd0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      raddr1 = vecs[i].wd;
      raddr2 = vecs[i].wd;
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tbl: scoreboard empty at entry %0d", i);
      end else begin
        e = exp_q.pop_front();
        chk("tbl_rd1", rdata1, e);
        chk("tbl_rd2", rdata2, e);
      end
    end

    // Reset mid-flight: r6 in MEM is lost
    tick();
    drive_ex(5'd6, 1'b1, 32'h66);
    raddr1 = 5'd1;
    tick();
    drive_ex(5'd0, 1'b0, 32'h0);
    settle();
    chk("pre_rst_mem_wdata", mem_wdata, 32'h66);
    chk("pre_rst_r1", rdata1, 32'h1111_1111);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_wdata", mem_wdata, 32'h0);
    chk("async_rst_mem_wreg", {31'b0, mem_wreg}, 32'h0);
    chk("async_rst_r1", rdata1, 32'h0);
    tick();
    rst = 1'b0;
    raddr1 = 5'd6;
    tick();
    tick();
    tick();
    settle();
    chk("rst_r6_lost", rdata1, 32'h0);
    chk("rst_wb_wreg_after", {31'b0, wb_wreg}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
